// File: rtl/fp4_fft_pkg.sv
// Shared constants and read-side state encoding for the FP4 FFT ping-pong
// sample memory sequencer.
package fp4_fft_pkg;

    localparam int FP4_ADDR_W = 5;
    localparam int FP4_DEPTH  = 2 ** FP4_ADDR_W;
    localparam int FP4_DATA_W = 8;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t R_IDLE    = 2'd0;
    localparam rd_state_t R_STREAM  = 2'd1;
    localparam rd_state_t R_COMPUTE = 2'd2;

endpackage : fp4_fft_pkg

// File: rtl/fp4_fft_bitrev.sv
// Combinational address bit-reversal over ADDR_W bits. Used to store each
// frame in decimation-in-time input order.
module fp4_fft_bitrev #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out
);

    // Mirror the index bits: LSB of the natural index becomes the MSB.
    always_comb begin
        addr_out = {ADDR_W{1'b0}};
        for (int i = 0; i < ADDR_W; i++) begin
            addr_out[i] = addr_in[ADDR_W-1-i];
        end
    end

endmodule : fp4_fft_bitrev

// File: rtl/fp4_fft_pingpong_ctrl.sv
// Sequencer for the FP4 FFT ping-pong sample memory.
// Fills one bank from the source stream while the other bank is burst out to
// the FFT engine; banks swap once a frame is full and the engine is free.
// Optional build macro FP4_FFT_BITREV_EN: write addresses are bit-reversed
// so each bank holds its frame in DIT input order (smp_index stays in
// memory order).
module fp4_fft_pingpong_ctrl
    import fp4_fft_pkg::*;
#(
    parameter int ADDR_W = FP4_ADDR_W,
    parameter int DATA_W = FP4_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en_1,
    output logic [ADDR_W-1:0] wr_addr_1,
    output logic [DATA_W-1:0] wr_data_1,
    output logic              bank_sel,
    output logic [ADDR_W-1:0] rd_addr_0,
    input  logic [DATA_W-1:0] rd_data_0,
    output logic              smp_valid,
    output logic [DATA_W-1:0] smp_data,
    output logic [ADDR_W-1:0] smp_index,
    input  logic              proc_done,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_cnt_nxt;
    logic              fill_full;
    logic              fill_full_nxt;
    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_cnt_nxt;
    logic              bank_sel_nxt;
    logic [7:0]        frame_cnt_nxt;
    logic              accept;
    logic              swap;
    logic [ADDR_W-1:0] wr_addr_map;

`ifdef FP4_FFT_BITREV_EN
    fp4_fft_bitrev #(
        .ADDR_W (ADDR_W)
    ) u_bitrev (
        .addr_in  (wr_cnt),
        .addr_out (wr_addr_map)
    );
`else
    assign wr_addr_map = wr_cnt;
`endif

    // in_ready is a flop, so it already reflects this cycle's fill_full.
    assign accept = in_valid & in_ready;
    assign swap   = fill_full & (rd_state == R_IDLE);

    // The read address is the read counter itself; it holds outside streaming.
    assign rd_addr_0 = rd_cnt;
    // Memory data already has the 1-cycle latency that smp_valid/index model.
    assign smp_data  = rd_data_0;

    // Write-side next state: advance on accept, mark the bank full on the last slot.
    always_comb begin
        wr_cnt_nxt    = wr_cnt;
        fill_full_nxt = fill_full;
        if (swap) begin
            fill_full_nxt = 1'b0;
        end else if (accept) begin
            wr_cnt_nxt = wr_cnt + CNT_ONE;
            if (wr_cnt == CNT_LAST) begin
                fill_full_nxt = 1'b1;
            end else begin
                fill_full_nxt = fill_full;
            end
        end else begin
            wr_cnt_nxt    = wr_cnt;
            fill_full_nxt = fill_full;
        end
    end

    // Read FSM next state, including the bank swap taken from R_IDLE.
    always_comb begin
        rd_state_nxt  = rd_state;
        rd_cnt_nxt    = rd_cnt;
        bank_sel_nxt  = bank_sel;
        frame_cnt_nxt = frame_cnt;
        case (rd_state)
            R_IDLE: begin
                if (fill_full) begin
                    rd_state_nxt  = R_STREAM;
                    rd_cnt_nxt    = CNT_ZERO;
                    bank_sel_nxt  = ~bank_sel;
                    frame_cnt_nxt = frame_cnt + 8'd1;
                end else begin
                    rd_state_nxt = R_IDLE;
                end
            end
            R_STREAM: begin
                if (rd_cnt == CNT_LAST) begin
                    rd_state_nxt = R_COMPUTE;
                end else begin
                    rd_cnt_nxt = rd_cnt + CNT_ONE;
                end
            end
            R_COMPUTE: begin
                if (proc_done) begin
                    rd_state_nxt = R_IDLE;
                end else begin
                    rd_state_nxt = R_COMPUTE;
                end
            end
            default: begin
                rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Write-side state and the registered memory write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= CNT_ZERO;
            fill_full <= 1'b0;
            in_ready  <= 1'b0;
            wr_en_1   <= 1'b0;
            wr_addr_1 <= CNT_ZERO;
            wr_data_1 <= {DATA_W{1'b0}};
        end else begin
            wr_cnt    <= wr_cnt_nxt;
            fill_full <= fill_full_nxt;
            in_ready  <= ~fill_full_nxt;
            wr_en_1   <= accept;
            if (accept) begin
                wr_addr_1 <= wr_addr_map;
                wr_data_1 <= in_data;
            end else begin
                wr_addr_1 <= wr_addr_1;
                wr_data_1 <= wr_data_1;
            end
        end
    end

    // Read-side state, bank select, frame counter and engine-facing flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state  <= R_IDLE;
            rd_cnt    <= CNT_ZERO;
            bank_sel  <= 1'b0;
            frame_cnt <= 8'd0;
            smp_valid <= 1'b0;
            smp_index <= CNT_ZERO;
            busy      <= 1'b0;
        end else begin
            rd_state  <= rd_state_nxt;
            rd_cnt    <= rd_cnt_nxt;
            bank_sel  <= bank_sel_nxt;
            frame_cnt <= frame_cnt_nxt;
            smp_valid <= (rd_state == R_STREAM);
            smp_index <= rd_cnt;
            busy      <= (rd_state_nxt != R_IDLE);
        end
    end

endmodule : fp4_fft_pingpong_ctrl

// File: tb/tb_fp4_fft_pingpong_ctrl.sv
// Self-checking bench for fp4_fft_pingpong_ctrl with an attached two-bank
// memory and a frame-level reference model of the sequencer.
module tb_fp4_fft_pingpong_ctrl;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       proc_done = 1'b0;
    logic       in_ready, wr_en_1, bank_sel, smp_valid, busy;
    logic [4:0] wr_addr_1, rd_addr_0, smp_index;
    logic [7:0] wr_data_1, rd_data_0, smp_data, frame_cnt;

    int total = 0;
    int bad   = 0;

    fp4_fft_pingpong_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en_1   (wr_en_1),
        .wr_addr_1 (wr_addr_1),
        .wr_data_1 (wr_data_1),
        .bank_sel  (bank_sel),
        .rd_addr_0 (rd_addr_0),
        .rd_data_0 (rd_data_0),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .smp_index (smp_index),
        .proc_done (proc_done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Ping-pong memory: bank_sel=1 reads bank1 and writes bank0.
    logic [7:0] mem0 [N];
    logic [7:0] mem1 [N];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_0 <= 8'd0;
        end else begin
            if (wr_en_1) begin
                if (bank_sel) mem0[wr_addr_1] <= wr_data_1;
                else          mem1[wr_addr_1] <= wr_data_1;
            end
            rd_data_0 <= bank_sel ? mem1[rd_addr_0] : mem0[rd_addr_0];
        end
    end

    // Memory position of the j-th sample of a frame.
    function automatic logic [4:0] map_addr(input int j);
        int r;
        int v;
        r = j % N;
`ifdef FP4_FFT_BITREV_EN
        v = j % N;
        r = 0;
        for (int b = 0; b < 5; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
`endif
        v = r;
        return v[4:0];
    endfunction

    // ---------------- reference model ----------------
    int         m_nfill, m_left, m_rd;
    bit         m_wait;
    logic [7:0] fill [N];
    logic [7:0] rdf  [N];
    logic       m_ready, m_wr_en, m_bank, m_sv, m_busy;
    logic [4:0] m_wr_addr, m_si;
    logic [7:0] m_wr_data, m_frame, m_sd;

    task automatic model_reset();
        m_nfill = 0; m_left = 0; m_rd = 0; m_wait = 1'b0;
        m_ready = 1'b0; m_wr_en = 1'b0; m_bank = 1'b0; m_sv = 1'b0; m_busy = 1'b0;
        m_wr_addr = 5'd0; m_si = 5'd0; m_wr_data = 8'd0; m_frame = 8'd0; m_sd = 8'd0;
    endtask

    // One clock edge: samples in fill order, engine as "addresses left to issue".
    task automatic model_edge();
        bit acc, idle, full;
        int old_rd, old_left;
        logic [4:0] ri;
        acc      = in_valid && m_ready;
        idle     = (m_left == 0) && !m_wait;
        full     = (m_nfill == N);
        old_rd   = m_rd;
        old_left = m_left;
        m_wr_en  = acc;
        if (acc) begin
            m_wr_addr = map_addr(m_nfill);
            m_wr_data = in_data;
        end
        m_sv = (old_left > 0);
        ri   = old_rd[4:0];
        m_si = ri;
        if (old_left > 0) m_sd = rdf[map_addr(old_rd)];
        if (full && idle) begin
            m_nfill = 0; m_bank = !m_bank; m_frame = m_frame + 8'd1;
            m_left = N; m_rd = 0; rdf = fill;
        end else if (acc) begin
            fill[m_nfill] = in_data;
            m_nfill++;
        end
        if (old_left > 0) begin
            m_left--;
            if (m_left > 0) m_rd++;
            else            m_wait = 1'b1;
        end else if (m_wait && proc_done) begin
            m_wait = 1'b0;
        end
        m_ready = (m_nfill != N);
        m_busy  = (m_left > 0) || m_wait;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",  int'(in_ready),  int'(m_ready));
        chk("wr_en_1",   int'(wr_en_1),   int'(m_wr_en));
        chk("wr_addr_1", int'(wr_addr_1), int'(m_wr_addr));
        chk("wr_data_1", int'(wr_data_1), int'(m_wr_data));
        chk("bank_sel",  int'(bank_sel),  int'(m_bank));
        chk("rd_addr_0", int'(rd_addr_0), m_rd);
        chk("smp_valid", int'(smp_valid), int'(m_sv));
        chk("smp_index", int'(smp_index), int'(m_si));
        chk("busy",      int'(busy),      int'(m_busy));
        chk("frame_cnt", int'(frame_cnt), int'(m_frame));
        if (m_sv) chk("smp_data", int'(smp_data), int'(m_sd));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        logic       e_ready;
        logic       e_wren;
        logic [4:0] e_addr;
        logic [7:0] e_data;
        logic       e_bank;
    } vec_t;

    vec_t vec [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit found;
        logic [7:0] v;

        model_reset();
        vec[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,        8'h00, 1'b0};
        vec[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0,        8'h00, 1'b0};
        vec[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, map_addr(0), 8'h00, 1'b0};
        vec[3] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, map_addr(1), 8'h01, 1'b0};
        vec[4] = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, map_addr(2), 8'h02, 1'b0};

        // Test 1: reset state and first accepts from the vector table.
        for (int i = 0; i < 5; i++) begin
            rst = vec[i].rst; in_valid = vec[i].vld; in_data = vec[i].dat; proc_done = 1'b0;
            if (!rst) model_reset();
            tick();
            chk("vec_ready", int'(in_ready),  int'(vec[i].e_ready));
            chk("vec_wren",  int'(wr_en_1),   int'(vec[i].e_wren));
            chk("vec_addr",  int'(wr_addr_1), int'(vec[i].e_addr));
            chk("vec_data",  int'(wr_data_1), int'(vec[i].e_data));
            chk("vec_bank",  int'(bank_sel),  int'(vec[i].e_bank));
        end
        for (int i = 3; i < N; i++) begin
            in_data = 8'(i);
            tick();
            chk("t1_addr", int'(wr_addr_1), int'(map_addr(i)));
        end
        chk("t1_full_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        chk("t1_swap_bank",  int'(bank_sel),  1);
        chk("t1_swap_frame", int'(frame_cnt), 1);
        chk("t1_wren_off",   int'(wr_en_1),   0);

        // Tests 2/3: stream frame 1 while frame 2 fills; engine holds proc_done.
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid = (k < N); in_data = 8'h80 + 8'(k);
            tick();
            if (smp_valid) begin
                cnt++;
                chk("t2_busy", int'(busy), 1);
                chk("t2_data", int'(smp_data), int'(map_addr(int'(smp_index))));
            end
        end
        in_valid = 1'b0;
        chk("t2_valid_cycles", cnt, N);
        for (int k = 0; k < 10; k++) tick();
        chk("t3_ready_held", int'(in_ready), 0);
        chk("t3_no_swap",    int'(bank_sel), 1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk("t3_idle", int'(busy), 0);
        chk("t3_bank_before", int'(bank_sel), 1);
        tick();
        chk("t3_swap_bank",  int'(bank_sel),  0);
        chk("t3_swap_frame", int'(frame_cnt), 2);
        tick();
        chk("t3_first_valid", int'(smp_valid), 1);
        chk("t3_first_data",  int'(smp_data),  int'(8'h80 + 8'(map_addr(0))));
        for (int k = 0; k < 32; k++) tick();

        // Test 4: gapped source, proc_done in R_COMPUTE, R_IDLE and R_STREAM.
        v = 8'h40;
        for (int c = 0; c < 150; c++) begin
            in_valid  = (c % 3 == 0);
            in_data   = v;
            proc_done = (c == 2) || (c == 10) || (c == 100);
            if (in_valid && in_ready) v = v + 8'd1;
            tick();
        end
        proc_done = 1'b0; in_valid = 1'b0;
        chk("t4_frame", int'(frame_cnt), 3);
        chk("t4_busy",  int'(busy), 1);

        // Test 5: reset asserted mid-stream after index 10.
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            in_valid = 1'b1; in_data = 8'($urandom); proc_done = (c == 0);
            tick();
            if (smp_valid && smp_index == 5'd10) found = 1'b1;
        end
        in_valid = 1'b0; proc_done = 1'b0;
        chk("t5_reach_idx10", int'(found), 1);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t5_swap_bank",  int'(bank_sel),  1);
        chk("t5_swap_frame", int'(frame_cnt), 1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1200; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            proc_done = ($urandom_range(0, 7) == 0);
            tick();
        end
        in_valid = 1'b0; proc_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp4_fft_pingpong_ctrl
